mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single memory port (data + program memory, UART at 001h) between two requesters.
- Requester 0 is the CPU bus; requester 1 is the boot loader / debug master that writes program memory at 100h-1ffh.
- Round-robin grant with burst lock and anti-starvation forcing.
- Synchronous-read memory behind it: read data returns one cycle after the address; the arbiter routes it back to the owner of that read.

Parameters:
ADDR_WIDTH, 10, address width of memory and both requester ports
DATA_WIDTH, 16, data width
MAX_WAIT, 8, consecutive denied-request cycles after which the waiting requester is forced to win (1..255)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
m0_req  in  1  requester 0 access request, held until granted
m0_we  in  1  1 = write, 0 = read
m0_lock  in  1  keep ownership for next cycle if m0 still requesting
m0_addr  in  ADDR_WIDTH  address
m0_wdata  in  DATA_WIDTH  write data
m0_gnt  out  1  access accepted this cycle
m0_rvalid  out  1  read data valid (cycle after granted read)
m0_rdata  out  DATA_WIDTH  read data
m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0 for requester 1
mem_addr  out  ADDR_WIDTH  memory address
mem_wr  out  1  memory write strobe
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after mem_addr

Behaviour:
- Reset (rst_n low, asynchronous): last_win=1, lock_owner=none, wait0=wait1=0, rd_pend=0, rd_owner=0, m0/m1_rvalid=0, m0/m1_rdata=0. gnt, mem_wr forced 0 while in reset. Pending read dropped; no rvalid after reset release.
- Grant is combinational in the request cycle. At most one gnt high per cycle. One access per granted cycle.
- Winner selection, in priority order:
  1. If wait1 >= MAX_WAIT and m1_req, m1 wins; symmetric for m0. Forcing overrides lock.
  2. Else if lock_owner = X and mX_req, X wins.
  3. Else if only one requests, it wins.
  4. Else if both request, the requester != last_win wins.
- Memory mux: the winner drives mem_addr, mem_wdata and mem_wr = winner's we. With no winner: mem_addr=0, mem_wdata=0, mem_wr=0. Address 000h is invalid, so an idle cycle is harmless.
- State registers on each clock edge:
  - last_win <= winner when any grant.
  - lock_owner <= winner if winner's lock=1, else none. Lock is released when the owner drops req or lock, or is overridden by forcing.
  - waitX <= 0 if mX_gnt or !mX_req, else waitX+1, saturating at 255.
  - rd_pend <= grant & !we; rd_owner <= winner.
- Read return: the cycle after a granted read, rvalid of rd_owner=1 for exactly one cycle and its rdata <= mem_rdata. rdata of the other requester holds its previous value. Write grants produce no rvalid.
- Back-to-back reads: allowed every cycle, even alternating owners. Each return is routed by the registered rd_owner, so order matches grant order.
- Request during own rvalid cycle: permitted, and it is arbitrated normally.
- Requester protocol: it changes addr/we/wdata only after gnt. The bench flags a deasserted req before gnt as a protocol violation; the arbiter just stops considering it.
- Latency: grant 0 cycles when uncontended. Read data 1 cycle after grant. Worst-case wait for a requester is MAX_WAIT+1 cycles regardless of the other's lock.

Test Plan:
1. After reset, m0_req read addr 020h, memory returns 1234h -> m0_gnt same cycle, mem_addr=020h, mem_wr=0; next cycle m0_rvalid=1, m0_rdata=1234h; m1_rvalid=0.
2. m0 and m1 both request every cycle from reset, no lock -> grants alternate m0,m1,m0,m1; rvalid/rdata go to the matching owner each cycle.
3. m1 write addr 100h data abcdh while m0 idle -> m1_gnt=1, mem_wr=1, mem_addr=100h, mem_wdata=abcdh; no rvalid next cycle.
4. m0 requests continuously with m0_lock=1, m1 requests from cycle 1, MAX_WAIT=8 -> m0 granted 8 straight contended cycles; m1 granted on the 9th; lock resumes for m0 afterward.
5. m0 read granted, rst_n pulsed low asynchronously before the next edge -> all rvalid=0, rdata=0, no grants during reset; first grant after release goes to m0 on a tie.
6. Idle bus, no requests for 4 cycles -> mem_addr=0, mem_wr=0, gnt=0, waits remain 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a shared synchronous-read memory port.
// Supports burst lock and wait-count forcing, and routes read data back to the owner of each read.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_m0_req,
    input  logic                  i_m0_we,
    input  logic                  i_m0_lock,
    input  logic [ADDR_WIDTH-1:0] i_m0_addr,
    input  logic [DATA_WIDTH-1:0] i_m0_wdata,
    output logic                  o_m0_gnt,
    output logic                  o_m0_rvalid,
    output logic [DATA_WIDTH-1:0] o_m0_rdata,
    input  logic                  i_m1_req,
    input  logic                  i_m1_we,
    input  logic                  i_m1_lock,
    input  logic [ADDR_WIDTH-1:0] i_m1_addr,
    input  logic [DATA_WIDTH-1:0] i_m1_wdata,
    output logic                  o_m1_gnt,
    output logic                  o_m1_rvalid,
    output logic [DATA_WIDTH-1:0] o_m1_rdata,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_wr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    logic                  r_last_win;
    logic                  r_lock_vld;
    logic                  r_lock_id;
    logic [7:0]            r_wait0;
    logic [7:0]            r_wait1;
    logic                  r_rd_pend;
    logic                  r_rd_owner;
    logic [DATA_WIDTH-1:0] r_m0_rdata;
    logic [DATA_WIDTH-1:0] r_m1_rdata;

    logic w_force0, w_force1;
    logic w_win_vld, w_win_id;
    logic w_gnt0, w_gnt1, w_any;
    logic w_we, w_lock;

    assign w_force0 = i_m0_req && (r_wait0 >= LP_MAX_WAIT);
    assign w_force1 = i_m1_req && (r_wait1 >= LP_MAX_WAIT);

    always_comb begin
        w_win_vld = 1'b0;
        w_win_id  = 1'b0;
        if (w_force0 && w_force1) begin
            w_win_vld = 1'b1;
            w_win_id  = ~r_last_win;
        end else if (w_force1) begin
            w_win_vld = 1'b1;
            w_win_id  = 1'b1;
        end else if (w_force0) begin
            w_win_vld = 1'b1;
            w_win_id  = 1'b0;
        end else if (r_lock_vld && (r_lock_id ? i_m1_req : i_m0_req)) begin
            w_win_vld = 1'b1;
            w_win_id  = r_lock_id;
        end else if (i_m0_req && i_m1_req) begin
            w_win_vld = 1'b1;
            w_win_id  = ~r_last_win;
        end else if (i_m0_req || i_m1_req) begin
            w_win_vld = 1'b1;
            w_win_id  = i_m1_req;
        end
    end

    // Grants are gated by reset so nothing reaches memory while rst_n is low.
    assign w_gnt0 = rst_n && w_win_vld && !w_win_id;
    assign w_gnt1 = rst_n && w_win_vld &&  w_win_id;
    assign w_any  = w_gnt0 || w_gnt1;
    assign w_we   = w_win_id ? i_m1_we   : i_m0_we;
    assign w_lock = w_win_id ? i_m1_lock : i_m0_lock;

    assign o_m0_gnt    = w_gnt0;
    assign o_m1_gnt    = w_gnt1;
    assign o_mem_addr  = w_gnt0 ? i_m0_addr  : (w_gnt1 ? i_m1_addr  : '0);
    assign o_mem_wdata = w_gnt0 ? i_m0_wdata : (w_gnt1 ? i_m1_wdata : '0);
    assign o_mem_wr    = w_any && w_we;

    // Memory data is valid in the return cycle itself; the registers hold it afterwards.
    assign o_m0_rvalid = r_rd_pend && !r_rd_owner;
    assign o_m1_rvalid = r_rd_pend &&  r_rd_owner;
    assign o_m0_rdata  = o_m0_rvalid ? i_mem_rdata : r_m0_rdata;
    assign o_m1_rdata  = o_m1_rvalid ? i_mem_rdata : r_m1_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_win <= 1'b1;
            r_lock_vld <= 1'b0;
            r_lock_id  <= 1'b0;
            r_wait0    <= 8'd0;
            r_wait1    <= 8'd0;
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            if (w_any) begin
                r_last_win <= w_win_id;
                r_rd_owner <= w_win_id;
            end
            r_lock_vld <= w_any && w_lock;
            r_lock_id  <= w_win_id;
            r_rd_pend  <= w_any && !w_we;

            if (w_gnt0 || !i_m0_req)  r_wait0 <= 8'd0;
            else if (r_wait0 != 8'hff) r_wait0 <= r_wait0 + 8'd1;
            if (w_gnt1 || !i_m1_req)  r_wait1 <= 8'd0;
            else if (r_wait1 != 8'hff) r_wait1 <= r_wait1 + 8'd1;

            if (o_m0_rvalid) r_m0_rdata <= i_mem_rdata;
            if (o_m1_rvalid) r_m1_rdata <= i_mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single access, write path, lock with forcing,
// async reset mid-read, and alternating contention, against a small memory model.
module tb_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [AW-1:0] m0_addr, m1_addr, mem_addr;
    logic [DW-1:0] m0_wdata, m1_wdata, mem_wdata, m0_rdata, m1_rdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_wr;
    logic [DW-1:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_lock(m0_lock),
        .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
        .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata),
        .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_lock(m1_lock),
        .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
        .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata),
        .o_mem_addr(mem_addr), .o_mem_wr(mem_wr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata)
    );

    // Synchronous-read memory: fixed contents plus the most recent write.
    logic          wr_seen = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        if (a == 10'h020) return 16'h1234;
        if (a == 10'h101) return 16'h5555;
        return {6'd0, a};
    endfunction

    always @(posedge clk) begin
        if (mem_wr) begin
            wr_seen <= 1'b1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
        end
        mem_rdata <= (wr_seen && wr_addr == mem_addr) ? wr_data : init_val(mem_addr);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        m0_req = 1'b1; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;

        // reset state, requests held high to show grants are blocked
        @(negedge clk);
        check_eq("rst_gnt0", 32'(m0_gnt), 32'd0);
        check_eq("rst_gnt1", 32'(m1_gnt), 32'd0);
        check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
        check_eq("rst_rvalid0", 32'(m0_rvalid), 32'd0);
        check_eq("rst_rdata0", 32'(m0_rdata), 32'd0);
        #2;
        m0_req = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
        rst_n = 1'b1;

        // single uncontended read
        next_cycle();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 10'h020;
        @(negedge clk);
        check_eq("t1_gnt0", 32'(m0_gnt), 32'd1);
        check_eq("t1_gnt1", 32'(m1_gnt), 32'd0);
        check_eq("t1_addr", 32'(mem_addr), 32'h020);
        check_eq("t1_wr", 32'(mem_wr), 32'd0);
        next_cycle();
        m0_req = 1'b0;
        @(negedge clk);
        check_eq("t1_rvalid0", 32'(m0_rvalid), 32'd1);
        check_eq("t1_rdata0", 32'(m0_rdata), 32'h1234);
        check_eq("t1_rvalid1", 32'(m1_rvalid), 32'd0);

        // idle bus
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            @(negedge clk);
            check_eq("t6_addr", 32'(mem_addr), 32'd0);
            check_eq("t6_wr", 32'(mem_wr), 32'd0);
            check_eq("t6_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
            check_eq("t6_rvalid0", 32'(m0_rvalid), 32'd0);
            check_eq("t6_rdata0_hold", 32'(m0_rdata), 32'h1234);
        end

        // m1 write, then read back through the memory
        next_cycle();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 10'h100; m1_wdata = 16'habcd;
        @(negedge clk);
        check_eq("t3_gnt1", 32'(m1_gnt), 32'd1);
        check_eq("t3_gnt0", 32'(m0_gnt), 32'd0);
        check_eq("t3_wr", 32'(mem_wr), 32'd1);
        check_eq("t3_addr", 32'(mem_addr), 32'h100);
        check_eq("t3_wdata", 32'(mem_wdata), 32'habcd);
        next_cycle();
        m1_we = 1'b0;
        @(negedge clk);
        check_eq("t3_no_rvalid0", 32'(m0_rvalid), 32'd0);
        check_eq("t3_no_rvalid1", 32'(m1_rvalid), 32'd0);
        check_eq("t3_rd_gnt1", 32'(m1_gnt), 32'd1);
        next_cycle();
        m1_req = 1'b0;
        @(negedge clk);
        check_eq("t3_rvalid1", 32'(m1_rvalid), 32'd1);
        check_eq("t3_rdata1", 32'(m1_rdata), 32'habcd);
        check_eq("t3_rdata0_hold", 32'(m0_rdata), 32'h1234);

        // m0 locks, m1 waits 8 contended cycles then is forced through
        for (int k = 0; k < 13; k++) begin
            next_cycle();
            if (k == 0) begin
                m0_req = 1'b1; m0_lock = 1'b1; m0_we = 1'b0; m0_addr = 10'h020;
            end
            if (k == 1) begin
                m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'h101;
            end
            @(negedge clk);
            check_eq($sformatf("t4_gnt0_c%0d", k), 32'(m0_gnt), 32'(k != 9));
            check_eq($sformatf("t4_gnt1_c%0d", k), 32'(m1_gnt), 32'(k == 9));
            if (k == 10) begin
                check_eq("t4_rvalid1", 32'(m1_rvalid), 32'd1);
                check_eq("t4_rdata1", 32'(m1_rdata), 32'h5555);
            end
        end
        next_cycle();
        m0_req = 1'b0; m0_lock = 1'b0; m1_req = 1'b0;

        // async reset between a granted read and its return
        next_cycle();
        m0_req = 1'b1; m0_addr = 10'h020;
        @(negedge clk);
        check_eq("t5_gnt0_pre", 32'(m0_gnt), 32'd1);
        #2;
        rst_n = 1'b0;
        m1_req = 1'b1; m1_addr = 10'h101;
        #1;
        check_eq("t5_gnt_in_rst", 32'({m1_gnt, m0_gnt}), 32'd0);
        check_eq("t5_wr_in_rst", 32'(mem_wr), 32'd0);
        check_eq("t5_rdata0_rst", 32'(m0_rdata), 32'd0);
        check_eq("t5_rdata1_rst", 32'(m1_rdata), 32'd0);
        next_cycle();
        check_eq("t5_rvalid_in_rst", 32'({m1_rvalid, m0_rvalid}), 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_eq("t5_first_gnt0", 32'(m0_gnt), 32'd1);
        check_eq("t5_first_gnt1", 32'(m1_gnt), 32'd0);
        check_eq("t5_dropped_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);

        // both requesting every cycle: strict alternation, data routed to the reader
        for (int k = 1; k < 8; k++) begin
            next_cycle();
            @(negedge clk);
            check_eq($sformatf("t2_gnt0_c%0d", k), 32'(m0_gnt), 32'(k % 2 == 0));
            check_eq($sformatf("t2_gnt1_c%0d", k), 32'(m1_gnt), 32'(k % 2 == 1));
            check_eq($sformatf("t2_rvalid0_c%0d", k), 32'(m0_rvalid), 32'(k % 2 == 1));
            check_eq($sformatf("t2_rvalid1_c%0d", k), 32'(m1_rvalid), 32'(k % 2 == 0));
            if (k % 2 == 1) check_eq("t2_rdata0", 32'(m0_rdata), 32'h1234);
            else            check_eq("t2_rdata1", 32'(m1_rdata), 32'h5555);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
